// File: rtl/eg_xgmii_pkg.sv
// Shared XGMII constants, word bundle and scheduler state
// for the TX scheduling slice.
package eg_xgmii_pkg;

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_CTL   = 8'hFF;
  localparam logic [63:0] ERROR_WORD = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  ERROR_CTL  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP
  } tx_state_e;

  typedef struct packed {
    logic [63:0] txd;
    logic [7:0]  txctl;
  } xgmii_word_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer
// moves only when a grant is taken.
module rr_arbiter2
  import eg_xgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when requester 1 holds the most recent grant.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// Merges two pre-encoded XGMII frame streams onto one
// PCS port with round-robin grant and inter-packet gap.
module xgmii_tx_scheduler
  import eg_xgmii_pkg::*;
#(
  parameter int unsigned IPG_WORDS = 1
) (
  input  logic        i_txc,
  input  logic        i_reset,
  input  logic [63:0] i_req0_txd,
  input  logic [7:0]  i_req0_txctl,
  input  logic        i_req0_valid,
  input  logic        i_req0_last,
  output logic        o_req0_ready,
  input  logic [63:0] i_req1_txd,
  input  logic [7:0]  i_req1_txctl,
  input  logic        i_req1_valid,
  input  logic        i_req1_last,
  output logic        o_req1_ready,
  input  logic        i_tx_ready,
  output logic [63:0] o_txd,
  output logic [7:0]  o_txctl,
  output logic [1:0]  o_grant,
  output logic        o_underrun,
  output logic [15:0] o_frame_count
);

  localparam logic [3:0] IPG = 4'(IPG_WORDS);

  tx_state_e   state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] cnt_q, cnt_d;
  logic        under_q, under_d;
  xgmii_word_t out_q, out_d;

  logic [1:0]  req_valid;
  logic [1:0]  arb_gnt;
  logic        arb_en;
  logic        sel_valid;
  logic        sel_last;
  xgmii_word_t sel_word;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign arb_en    = (state_q == ST_IDLE) && i_tx_ready;

  rr_arbiter2 u_arb (
    .clk (i_txc),
    .rst (i_reset),
    .en  (arb_en),
    .req (req_valid),
    .gnt (arb_gnt)
  );

  always_comb begin
    if (grant_q[1]) begin
      sel_valid = i_req1_valid;
      sel_last  = i_req1_last;
      sel_word  = '{txd: i_req1_txd, txctl: i_req1_txctl};
    end else begin
      sel_valid = i_req0_valid;
      sel_last  = i_req0_last;
      sel_word  = '{txd: i_req0_txd, txctl: i_req0_txctl};
    end
  end

  assign o_req0_ready = (state_q == ST_FRAME) & grant_q[0] & i_tx_ready;
  assign o_req1_ready = (state_q == ST_FRAME) & grant_q[1] & i_tx_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    under_d = 1'b0;
    if (i_tx_ready) begin
      unique case (state_q)
        ST_IDLE: begin
          out_d = '{txd: IDLE_WORD, txctl: IDLE_CTL};
          if (req_valid != 2'b00) begin
            grant_d = arb_gnt;
            state_d = ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (sel_valid) begin
            out_d = sel_word;
            if (sel_last) begin
              cnt_d   = cnt_q + 16'd1;
              grant_d = 2'b00;
              gap_d   = IPG;
              state_d = (IPG == 4'd0) ? ST_IDLE : ST_GAP;
            end
          end else begin
            // Starved mid-frame: poison the stream rather than stall it.
            out_d   = '{txd: ERROR_WORD, txctl: ERROR_CTL};
            under_d = 1'b1;
          end
        end
        ST_GAP: begin
          out_d = '{txd: IDLE_WORD, txctl: IDLE_CTL};
          if (gap_q <= 4'd1) begin
            gap_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_txc) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      gap_q   <= 4'd0;
      cnt_q   <= 16'd0;
      under_q <= 1'b0;
      out_q   <= '{txd: IDLE_WORD, txctl: IDLE_CTL};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      under_q <= under_d;
      out_q   <= out_d;
    end
  end

  assign o_txd         = out_q.txd;
  assign o_txctl       = out_q.txctl;
  assign o_grant       = grant_q;
  assign o_underrun    = under_q;
  assign o_frame_count = cnt_q;

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed bench for xgmii_tx_scheduler with
// hand-computed expected words, grants and counts.
module tb_xgmii_tx_scheduler;

  localparam logic [63:0] IW = 64'h0707070707070707;
  localparam logic [63:0] EW = 64'hFEFEFEFEFEFEFEFE;

  logic        i_txc = 1'b0;
  logic        i_reset;
  logic [63:0] i_req0_txd, i_req1_txd;
  logic [7:0]  i_req0_txctl, i_req1_txctl;
  logic        i_req0_valid, i_req1_valid;
  logic        i_req0_last, i_req1_last;
  logic        o_req0_ready, o_req1_ready;
  logic        i_tx_ready;
  logic [63:0] o_txd;
  logic [7:0]  o_txctl;
  logic [1:0]  o_grant;
  logic        o_underrun;
  logic [15:0] o_frame_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_txc = ~i_txc;

  xgmii_tx_scheduler #(.IPG_WORDS(1)) dut (
    .i_txc         (i_txc),
    .i_reset       (i_reset),
    .i_req0_txd    (i_req0_txd),
    .i_req0_txctl  (i_req0_txctl),
    .i_req0_valid  (i_req0_valid),
    .i_req0_last   (i_req0_last),
    .o_req0_ready  (o_req0_ready),
    .i_req1_txd    (i_req1_txd),
    .i_req1_txctl  (i_req1_txctl),
    .i_req1_valid  (i_req1_valid),
    .i_req1_last   (i_req1_last),
    .o_req1_ready  (o_req1_ready),
    .i_tx_ready    (i_tx_ready),
    .o_txd         (o_txd),
    .o_txctl       (o_txctl),
    .o_grant       (o_grant),
    .o_underrun    (o_underrun),
    .o_frame_count (o_frame_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_txc);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_txd"}, o_txd, IW);
    chk({tag, "_ctl"}, {56'd0, o_txctl}, 64'hFF);
  endtask

  int           fl [2];
  int           ix [2];
  int           k;
  int           cyc;
  logic [1:0]   exp_g [4];
  logic [1:0]   g_snap;
  logic         acc0, acc1;
  logic [63:0]  w_snap;
  logic [7:0]   c_snap;

  function automatic logic [63:0] mk(input int r, input int f, input int i);
    return {32'hC0DE0000 + 32'(r), 16'(f), 16'(i)};
  endfunction

  initial begin
    i_reset = 1'b0;
    i_req0_txd = '0; i_req0_txctl = '0; i_req0_valid = 0; i_req0_last = 0;
    i_req1_txd = '0; i_req1_txctl = '0; i_req1_valid = 0; i_req1_last = 0;
    i_tx_ready = 1'b1;

    // reset state
    do_reset();
    chk_idle("rst");
    chk("rst_grant", {62'd0, o_grant}, 64'd0);
    chk("rst_count", {48'd0, o_frame_count}, 64'd0);
    chk("rst_underrun", {63'd0, o_underrun}, 64'd0);
    chk("rst_ready", {62'd0, o_req1_ready, o_req0_ready}, 64'd0);

    // ten idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle10");
    end
    chk("idle10_count", {48'd0, o_frame_count}, 64'd0);

    // req0 three-word frame
    i_req0_valid = 1; i_req0_txd = 64'h1111_0000_0000_0000;
    i_req0_txctl = 8'h01; i_req0_last = 0;
    #1;
    chk("f3_ready_idle", {63'd0, o_req0_ready}, 64'd0);
    tick();
    chk("f3_grant", {62'd0, o_grant}, 64'd1);
    chk("f3_ready", {63'd0, o_req0_ready}, 64'd1);
    chk_idle("f3_arb");
    tick();
    chk("f3_w0", o_txd, 64'h1111_0000_0000_0000);
    chk("f3_c0", {56'd0, o_txctl}, 64'h01);
    i_req0_txd = 64'h1111_0000_0000_0001; i_req0_txctl = 8'h00;
    tick();
    chk("f3_w1", o_txd, 64'h1111_0000_0000_0001);
    i_req0_txd = 64'h1111_0000_0000_0002; i_req0_txctl = 8'hF0;
    i_req0_last = 1;
    tick();
    chk("f3_w2", o_txd, 64'h1111_0000_0000_0002);
    chk("f3_c2", {56'd0, o_txctl}, 64'hF0);
    chk("f3_count", {48'd0, o_frame_count}, 64'd1);
    chk("f3_gclr", {62'd0, o_grant}, 64'd0);
    i_req0_valid = 0; i_req0_last = 0;
    tick();
    chk_idle("f3_gap1");
    tick();
    chk_idle("f3_gap2");

    // both requesters continuously, 2-word frames
    do_reset();
    fl[0] = 2; fl[1] = 2; ix[0] = 0; ix[1] = 0; k = 0; cyc = 0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    while (k < 4 && cyc < 200) begin
      i_req0_valid = (fl[0] > 0);
      i_req0_txd   = mk(0, fl[0], ix[0]);
      i_req0_txctl = (ix[0] == 0) ? 8'h01 : 8'h00;
      i_req0_last  = (ix[0] == 1);
      i_req1_valid = (fl[1] > 0);
      i_req1_txd   = mk(1, fl[1], ix[1]);
      i_req1_txctl = (ix[1] == 0) ? 8'h01 : 8'h00;
      i_req1_last  = (ix[1] == 1);
      #1;
      acc0 = o_req0_ready & i_req0_valid;
      acc1 = o_req1_ready & i_req1_valid;
      g_snap = o_grant;
      w_snap = acc1 ? i_req1_txd : i_req0_txd;
      c_snap = acc1 ? i_req1_txctl : i_req0_txctl;
      tick();
      cyc++;
      if (acc0 || acc1) begin
        chk("rr_word", o_txd, w_snap);
        chk("rr_ctl", {56'd0, o_txctl}, {56'd0, c_snap});
        if (ix[acc1 ? 1 : 0] == 0) begin
          chk("rr_grant", {62'd0, g_snap}, {62'd0, exp_g[k]});
          ix[acc1 ? 1 : 0] = 1;
        end else begin
          ix[acc1 ? 1 : 0] = 0;
          fl[acc1 ? 1 : 0]--;
          k++;
        end
      end
    end
    if (k < 4) chk("rr_timeout", 64'(k), 64'd4);
    i_req0_valid = 0; i_req1_valid = 0;
    i_req0_last = 0; i_req1_last = 0;
    chk("rr_count", {48'd0, o_frame_count}, 64'd4);

    // tx_ready pause mid-frame
    do_reset();
    i_req0_valid = 1; i_req0_txd = 64'hA0; i_req0_txctl = 8'h01;
    tick();
    tick();
    chk("ps_w0", o_txd, 64'hA0);
    i_req0_txd = 64'hA1; i_req0_txctl = 8'h00;
    tick();
    chk("ps_w1", o_txd, 64'hA1);
    i_req0_txd = 64'hA2;
    i_tx_ready = 0;
    #1;
    chk("ps_ready0", {63'd0, o_req0_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ps_hold", o_txd, 64'hA1);
      chk("ps_hold_rdy", {63'd0, o_req0_ready}, 64'd0);
      chk("ps_hold_g", {62'd0, o_grant}, 64'd1);
    end
    i_tx_ready = 1;
    #1;
    chk("ps_ready1", {63'd0, o_req0_ready}, 64'd1);
    tick();
    chk("ps_w2", o_txd, 64'hA2);
    i_req0_txd = 64'hA3; i_req0_last = 1;
    tick();
    chk("ps_w3", o_txd, 64'hA3);
    chk("ps_count", {48'd0, o_frame_count}, 64'd1);
    i_req0_valid = 0; i_req0_last = 0;

    // req1 starves for one cycle
    do_reset();
    i_req1_valid = 1; i_req1_txd = 64'hB0; i_req1_txctl = 8'h01;
    tick();
    chk("ur_grant", {62'd0, o_grant}, 64'd2);
    tick();
    chk("ur_w0", o_txd, 64'hB0);
    chk("ur_pulse0", {63'd0, o_underrun}, 64'd0);
    i_req1_valid = 0;
    tick();
    chk("ur_err", o_txd, EW);
    chk("ur_errctl", {56'd0, o_txctl}, 64'hFF);
    chk("ur_pulse", {63'd0, o_underrun}, 64'd1);
    i_req1_valid = 1; i_req1_txd = 64'hB1; i_req1_txctl = 8'hF0;
    i_req1_last = 1;
    tick();
    chk("ur_w1", o_txd, 64'hB1);
    chk("ur_pulse_end", {63'd0, o_underrun}, 64'd0);
    chk("ur_count", {48'd0, o_frame_count}, 64'd1);
    i_req1_valid = 0; i_req1_last = 0;
    tick();
    tick();

    // reset during word 2 of a req0 frame
    i_req0_valid = 1; i_req0_txd = 64'hC0; i_req0_txctl = 8'h01;
    tick();
    tick();
    chk("mr_w0", o_txd, 64'hC0);
    i_req0_txd = 64'hC1;
    i_reset = 1;
    tick();
    i_reset = 0;
    chk_idle("mr");
    chk("mr_grant", {62'd0, o_grant}, 64'd0);
    chk("mr_count", {48'd0, o_frame_count}, 64'd0);
    chk("mr_ready", {63'd0, o_req0_ready}, 64'd0);
    i_req0_txd = 64'hD0;
    i_req1_valid = 1; i_req1_txd = 64'hE0;
    tick();
    chk("mr_rr_reset", {62'd0, o_grant}, 64'd1);
    i_req0_valid = 0; i_req1_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
